// File: rtl/risc_mgmt_exec_arb.sv
// Arbiter that lets N_EXT extension execute units share one core write-back port.
// A rotating pointer picks the next owner. The owner then runs until it signals
// done, raises an exception or times out. A completed result is committed
// through the shared port. The core can stall commit or flush the operation.
module risc_mgmt_exec_arb #(
  parameter int unsigned N_EXT   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [N_EXT-1:0]         req,
  input  logic [N_EXT-1:0]         done,
  input  logic [N_EXT-1:0]         exc_in,
  input  logic [N_EXT-1:0]         wen_in,
  input  logic [5*N_EXT-1:0]       waddr_in,
  input  logic [32*N_EXT-1:0]      wdata_in,
  input  logic                     core_stall,
  input  logic                     flush,
  output logic [N_EXT-1:0]         grant,
  output logic                     ext_busy,
  output logic                     reg_w,
  output logic [4:0]               reg_waddr,
  output logic [31:0]              reg_wdata,
  output logic                     exception,
  output logic                     timeout,
  output logic [$clog2(N_EXT)-1:0] owner_id
);

  localparam int unsigned LW        = $clog2(N_EXT);
  localparam logic [7:0]  TIMEOUT_V = 8'(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]    r_state, w_state_nxt;
  logic [LW-1:0] r_owner, w_owner_nxt;
  logic [LW-1:0] r_ptr, w_ptr_nxt;
  logic [7:0]    r_timer, w_timer_nxt;
  logic          r_wen, w_wen_nxt;
  logic [4:0]    r_waddr, w_waddr_nxt;
  logic [31:0]   r_wdata, w_wdata_nxt;
  logic          r_exc, w_exc_nxt;
  logic          r_to, w_to_nxt;

  logic          w_any;
  logic [LW-1:0] w_sel;
  logic          w_busy;
  logic          w_own_done;
  logic          w_own_exc;
  logic          w_own_wen;
  logic [4:0]    w_own_waddr;
  logic [31:0]   w_own_wdata;
  logic [LW-1:0] w_owner_inc;

  // Fields of the current owner; inputs from other extensions never reach the FSM.
  assign w_own_done  = done[r_owner];
  assign w_own_exc   = exc_in[r_owner];
  assign w_own_wen   = wen_in[r_owner];
  assign w_own_waddr = waddr_in[int'(r_owner)*5 +: 5];
  assign w_own_wdata = wdata_in[int'(r_owner)*32 +: 32];
  // N_EXT is a power of two, so the LW-bit add wraps modulo N_EXT.
  assign w_owner_inc = r_owner + 1'b1;

  // Round-robin pick: the first requester at or after r_ptr, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    // Walk offsets from high to low so the smallest offset wins.
    for (int i = N_EXT - 1; i >= 0; i--) begin
      logic [LW-1:0] idx;
      idx = r_ptr + LW'(i);
      if (req[idx]) begin
        w_any = 1'b1;
        w_sel = idx;
      end
    end
  end

  // Next-state logic for the FSM, timer, pointer, latched result and status pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_timer_nxt = r_timer;
    w_wen_nxt   = r_wen;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    w_exc_nxt   = 1'b0;
    w_to_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any && !core_stall && !flush) begin
          w_owner_nxt = w_sel;
          w_timer_nxt = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = w_owner_inc;
        end else if (w_own_exc) begin
          // An exception wins over a done in the same cycle, so nothing is written.
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = w_owner_inc;
          w_exc_nxt   = 1'b1;
        end else if (w_own_done) begin
          w_state_nxt = S_COMMIT;
          w_wen_nxt   = w_own_wen;
          w_waddr_nxt = w_own_waddr;
          w_wdata_nxt = w_own_wdata;
        end else if (r_timer == TIMEOUT_V) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = w_owner_inc;
          w_exc_nxt   = 1'b1;
          w_to_nxt    = 1'b1;
        end else if (!core_stall) begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      S_COMMIT: begin
        if (flush || !core_stall) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = w_owner_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight operation and pending pulses.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_timer <= '0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_exc   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_timer <= w_timer_nxt;
      r_wen   <= w_wen_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
      r_exc   <= w_exc_nxt;
      r_to    <= w_to_nxt;
    end
  end

  // Outputs: grant and busy come from state only; the write port fires in the unstalled COMMIT cycle.
  always_comb begin
    w_busy    = (r_state == S_RUN) || (r_state == S_COMMIT);
    grant     = w_busy ? (N_EXT'(1) << r_owner) : '0;
    ext_busy  = w_busy;
    reg_w     = (r_state == S_COMMIT) && !core_stall && !flush && r_wen && (r_waddr != 5'd0);
    reg_waddr = reg_w ? r_waddr : 5'd0;
    reg_wdata = reg_w ? r_wdata : 32'd0;
    exception = r_exc;
    timeout   = r_to;
    owner_id  = r_owner;
  end

endmodule

// File: doc/risc_mgmt_exec_arb.md
RISC_MGMT_EXEC_ARB -- requirements
Module: risc_mgmt_exec_arb

Interface
- REQ-001: Parameter N_EXT, default 4, number of extension execute units sharing the core write-back port (power of two, 2..8).
- REQ-002: Parameter TIMEOUT, default 255, maximum RUN cycles before forced abort; timer width 8 bits.
- REQ-003: CLK  in  1  single clock; all state updates on rising edge.
- REQ-004: nRST  in  1  reset; asynchronous, active-high.
- REQ-005: req  in  N_EXT  per-extension request for the shared execute port.
- REQ-006: done  in  N_EXT  per-extension one-cycle completion pulse.
- REQ-007: exc_in  in  N_EXT  per-extension exception indication.
- REQ-008: wen_in  in  N_EXT  per-extension register-write request, sampled with done.
- REQ-009: waddr_in  in  5*N_EXT  flattened destination register indices.
- REQ-010: wdata_in  in  32*N_EXT  flattened write data.
- REQ-011: core_stall  in  1  core pipeline stall; freezes arbitration and commit.
- REQ-012: flush  in  1  core flush; aborts current operation.
- REQ-013: grant  out  N_EXT  one-hot grant to the owning extension.
- REQ-014: ext_busy  out  1  stall request to the core while an operation is in flight.
- REQ-015: reg_w, reg_waddr, reg_wdata  out  1/5/32  shared write-back port.
- REQ-016: exception  out  1  one-cycle exception pulse; timeout  out  1  one-cycle pulse, set with exception on timer expiry.
- REQ-017: owner_id  out  log2(N_EXT)  index of current/last owner.

Function
- REQ-018: The FSM SHALL have states IDLE, RUN, COMMIT.
- REQ-019: In IDLE with any req bit set and core_stall low, the block SHALL select the first requester at or above rotating pointer ptr (wrapping modulo N_EXT), register it as owner, clear the timer, and enter RUN next cycle.
- REQ-020: In IDLE with core_stall high, no grant SHALL be issued.
- REQ-021: grant SHALL equal one-hot(owner) and ext_busy SHALL be 1 in RUN and COMMIT, else 0.
- REQ-022: In RUN the timer SHALL increment by 1 per cycle when core_stall is low and hold when high.
- REQ-023: In RUN, done[owner] SHALL latch wen_in/waddr_in/wdata_in of the owner and move to COMMIT; done/exc of non-owners SHALL be ignored.
- REQ-024: In RUN, exc_in[owner] SHALL pulse exception for one cycle and return to IDLE without write; exc_in has priority over done in the same cycle.
- REQ-025: In RUN, when timer equals TIMEOUT and neither done nor exc_in of owner is asserted, exception and timeout SHALL pulse for one cycle and the FSM SHALL return to IDLE.
- REQ-026: In COMMIT with core_stall low, reg_w SHALL be 1 for exactly one cycle if latched wen is 1 and latched waddr is nonzero; a write to x0 SHALL be suppressed.
- REQ-027: In COMMIT with core_stall high, the FSM SHALL hold COMMIT with reg_w 0 and latched data unchanged.
- REQ-028: reg_waddr/reg_wdata SHALL be 0 whenever reg_w is 0.
- REQ-029: On leaving RUN or COMMIT by any path, ptr SHALL become (owner+1) mod N_EXT.
- REQ-030: flush in RUN or COMMIT SHALL return to IDLE next cycle with no reg_w, no exception; flush overrides all other events; flush in IDLE SHALL block arbitration that cycle.
- REQ-031: Single requester repeatedly requesting SHALL be re-granted after one IDLE cycle (no starvation of lone requester).

Reset
- REQ-032: On nRST assertion, state SHALL be IDLE, ptr 0, owner_id 0, timer 0, latched data 0, and all outputs 0, immediately and asynchronously.
- REQ-033: Reset asserted mid-RUN or mid-COMMIT SHALL discard the operation with no reg_w or exception pulse.

Verification
- REQ-034: Reset, req=4'b0101 -> grant=4'b0001 in RUN; done[0] wen=1 waddr=5 wdata=0xDEADBEEF -> COMMIT reg_w=1 waddr=5 data 0xDEADBEEF one cycle; next grant=4'b0100.
- REQ-035: req=4'b1111 held, each owner done after 2 cycles -> grant order 0,1,2,3,0.
- REQ-036: Owner 1 never done, TIMEOUT=255 -> exception and timeout pulse together after 256 RUN cycles, no reg_w, ptr=2.
- REQ-037: done with waddr=0 wen=1 -> no reg_w; done with core_stall high in COMMIT for 3 cycles -> reg_w asserted only in first unstalled cycle.
- REQ-038: exc_in and done of owner same cycle -> exception pulse, no reg_w; flush in COMMIT -> no reg_w, IDLE next cycle.
- REQ-039: nRST asserted during RUN -> outputs 0 immediately, grant=0 after deassertion until new request.
